// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: drives one shared full-adder cell LSB first,
// chaining the carry through a flop and assembling the result in a shift register.
module serial_adder_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   op_a_q, op_b_q;
    logic [WIDTH-1:0]   sum_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic               cout_q, ovf_q;

    logic               last_bit;
    logic               fa_s, fa_cn;

    // Operands shift right as bits are consumed, so bit 0 is always bit "counter".
    assign fa_s     = op_a_q[0] ^ op_b_q[0] ^ carry_q;
    assign fa_cn    = (op_a_q[0] & op_b_q[0]) | (op_b_q[0] & carry_q) | (op_a_q[0] & carry_q);
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (which would infer a latch).
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)    state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:                  state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // Subtract is a + ~b + 1: invert b here, the +1 enters as carry-in.
                        op_a_q  <= a;
                        op_b_q  <= sub ? ~b : b;
                        carry_q <= sub;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
                    op_a_q  <= op_a_q >> 1;
                    op_b_q  <= op_b_q >> 1;
                    carry_q <= fa_cn;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_bit) begin
                        cout_q <= fa_cn;
                        ovf_q  <= carry_q ^ fa_cn;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule
